alu_seq_core: RTL



---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_core_if.sv | 29 ++
 rtl/alu_seq_core_shift_add_mul.sv | 52 +++++
 rtl/alu_seq_core.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode and state types for the sequential ALU
// Purpose: opcode and FSM state enumerations used by alu_seq_core, its bus
//          interface and the testbench.
// Ports:   none (package).
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_ACC = 3'b110,
        OP_CLR = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - start/done request bus between a requester and alu_seq_core
// Purpose: bundles the operation request and the registered response of the ALU.
// Ports (modport master = requester, slave = core):
//   start, op[2:0], a[W-1:0], b[W-1:0]        : request, driven by master
//   result[2W-1:0], carry, zero, err, busy, done : response, driven by slave
interface alu_seq_core_if #(
    parameter int W = 3
);
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;
    logic           err;
    logic           busy;
    logic           done;

    modport master (
        output start, op, a, b,
        input  result, carry, zero, err, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, carry, zero, err, busy, done
    );
endinterface

// File: rtl/alu_seq_core_shift_add_mul.sv
// rtl/alu_seq_core_shift_add_mul.sv - W-step unsigned shift-add multiplier
// Purpose: computes a*b exactly in 2W bits, one partial product per clock.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   load_i            : latch a_i/b_i and take the first partial product
//   a_i, b_i [W-1:0]  : operands
//   product_o [2W-1:0]: running/final product
//   valid_o           : all W partial products accumulated
module shift_add_mul #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] product_o,
    output logic           valid_o
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;

    // The load edge already accumulates bit 0, so W edges in total
    // (load plus W-1 further steps) complete the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= CW'(W);
        end else if (load_i) begin
            prod_q   <= b_i[0] ? {{W{1'b0}}, a_i} : '0;
            mcand_q  <= {{(W-1){1'b0}}, a_i, 1'b0};
            mplier_q <= b_i >> 1;
            cnt_q    <= CW'(1);
        end else if (cnt_q != CW'(W)) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign product_o = prod_q;
    assign valid_o   = (cnt_q == CW'(W));
endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - sequential ALU with accumulator and optional multiplier
// Purpose: executes ADD/SUB/AND/OR/XOR/ACC/CLR in one edge; MUL takes W edges
//          through shift_add_mul when ALU_SEQ_MUL_EN is defined, otherwise
//          MUL completes at once with err=1 and result=0.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_core_if.slave (start/op/a/b in; result/carry/zero/
//              err/busy/done out). bus.W must equal W.
// Config macro: ALU_SEQ_MUL_EN
import alu_seq_pkg::*;

module alu_seq_core #(
    parameter int W = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_core_if.slave bus
);
    localparam int RW = 2 * W;

    alu_state_e    state_q, state_d;
    logic [RW-1:0] result_q, result_d;
    logic [RW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          busy;

    alu_op_e       op;
    logic [W:0]    add_sum;
    logic [W-1:0]  sub_diff;
    logic [RW:0]   acc_sum;

    assign op       = alu_op_e'(bus.op);
    assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_diff = bus.a - bus.b;
    assign acc_sum  = {1'b0, acc_q} + {{(RW+1-W){1'b0}}, bus.a};

`ifdef ALU_SEQ_MUL_EN
    logic          mul_load;
    logic [RW-1:0] mul_product;
    logic          mul_valid;

    shift_add_mul #(.W(W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load_i    (mul_load),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .product_o (mul_product),
        .valid_o   (mul_valid)
    );

    assign mul_load = (state_q == ST_IDLE) && bus.start && (op == OP_MUL);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef ALU_SEQ_MUL_EN
                if (bus.start && op == OP_MUL) begin
                    state_d = ST_MUL;
                end
`endif
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_valid) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: busy is purely state-decoded
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Datapath next values; everything holds unless a completion happens.
    always_comb begin
        result_d = result_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        done_d   = 1'b0;
        if (state_q == ST_IDLE && bus.start) begin
            done_d  = 1'b1;
            carry_d = 1'b0;
            err_d   = 1'b0;
            case (op)
                OP_ADD: begin
                    result_d = RW'(add_sum);
                    carry_d  = add_sum[W];
                end
                OP_SUB: begin
                    result_d = RW'(sub_diff);
                    carry_d  = (bus.a < bus.b);
                end
                OP_AND: result_d = RW'(bus.a & bus.b);
                OP_OR:  result_d = RW'(bus.a | bus.b);
                OP_XOR: result_d = RW'(bus.a ^ bus.b);
                OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                    // Only launches the multiplier; flags hold until it finishes.
                    done_d  = 1'b0;
                    carry_d = carry_q;
                    err_d   = err_q;
`else
                    result_d = '0;
                    err_d    = 1'b1;
`endif
                end
                OP_ACC: begin
                    acc_d    = acc_sum[RW-1:0];
                    result_d = acc_sum[RW-1:0];
                    carry_d  = acc_sum[RW];
                end
                OP_CLR: begin
                    acc_d    = '0;
                    result_d = '0;
                end
                default: ;
            endcase
            if (done_d) begin
                zero_d = (result_d == '0);
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_q == ST_MUL && mul_valid) begin
            result_d = mul_product;
            carry_d  = 1'b0;
            err_d    = 1'b0;
            zero_d   = (mul_product == '0);
            done_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy;
    assign bus.done   = done_q;
endmodule
